// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Op codes describe the ALU the parent attaches; the scheduler only forwards them.
package alu_sched_pkg;

    localparam int OP_W   = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam op_t OP_ADD = 5'd0;
    localparam op_t OP_SUB = 5'd1;
    localparam op_t OP_AND = 5'd2;
    localparam op_t OP_OR  = 5'd3;
    localparam op_t OP_XOR = 5'd4;
    localparam op_t OP_SLL = 5'd5;
    localparam op_t OP_SRL = 5'd6;
    localparam op_t OP_BEQ = 5'd7;
    localparam op_t OP_BNE = 5'd8;

    function automatic logic op_is_valid(input op_t op);
        return op <= OP_BNE;
    endfunction

endpackage

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one external ALU between two requesters.
// Every output comes straight from a flop; the ALU itself lives in the parent.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [OP_W-1:0]   op0,
    input  logic [OP_W-1:0]   op1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              res_fault,
    output logic              grant_id,
    output logic              alu_available,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_busy,
    input  logic              alu_fault
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_id_q, grant_id_d;
    logic              alu_available_q, alu_available_d;
    op_t               alu_op_q, alu_op_d;
    data_t             alu_in_a_q, alu_in_a_d;
    data_t             alu_in_b_q, alu_in_b_d;
    data_t             result_q, result_d;
    logic              res_fault_q, res_fault_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;

    logic              gnt_sel;
    logic [CNT_W-1:0]  cnt_inc;
    logic              finish_ok;
    logic              finish_to;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        grant_id_d      = grant_id_q;
        alu_available_d = alu_available_q;
        alu_op_d        = alu_op_q;
        alu_in_a_d      = alu_in_a_q;
        alu_in_b_d      = alu_in_b_q;
        result_d        = result_q;
        res_fault_d     = res_fault_q;
        done0_d         = 1'b0;
        done1_d         = 1'b0;
        finish_ok       = 1'b0;
        finish_to       = 1'b0;
        cnt_inc         = cnt_q + 1'b1;
        // A tie goes to whoever was not served last.
        gnt_sel         = (req0 && req1) ? ~grant_id_q : req1;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d         = ST_ISSUE;
                    cnt_d           = '0;
                    grant_id_d      = gnt_sel;
                    alu_available_d = 1'b1;
                    alu_op_d        = gnt_sel ? op1 : op0;
                    alu_in_a_d      = gnt_sel ? a1 : a0;
                    alu_in_b_d      = gnt_sel ? b1 : b0;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_inc;
                if (alu_busy) begin
                    state_d = ST_WAIT;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    finish_to = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (!alu_busy) begin
                    finish_ok = 1'b1;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    finish_to = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping alu_available for the DONE cycle is what re-arms the ALU.
        if (finish_ok || finish_to) begin
            state_d         = ST_DONE;
            alu_available_d = 1'b0;
            result_d        = finish_to ? '0 : alu_out;
            res_fault_d     = finish_to ? 1'b1 : alu_fault;
            done0_d         = ~grant_id_q;
            done1_d         = grant_id_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            grant_id_q      <= 1'b1;
            alu_available_q <= 1'b0;
            alu_op_q        <= '0;
            alu_in_a_q      <= '0;
            alu_in_b_q      <= '0;
            result_q        <= '0;
            res_fault_q     <= 1'b0;
            done0_q         <= 1'b0;
            done1_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            grant_id_q      <= grant_id_d;
            alu_available_q <= alu_available_d;
            alu_op_q        <= alu_op_d;
            alu_in_a_q      <= alu_in_a_d;
            alu_in_b_q      <= alu_in_b_d;
            result_q        <= result_d;
            res_fault_q     <= res_fault_d;
            done0_q         <= done0_d;
            done1_q         <= done1_d;
        end
    end

    assign done0         = done0_q;
    assign done1         = done1_q;
    assign result        = result_q;
    assign res_fault     = res_fault_q;
    assign grant_id      = grant_id_q;
    assign alu_available = alu_available_q;
    assign alu_op        = alu_op_q;
    assign alu_in_a      = alu_in_a_q;
    assign alu_in_b      = alu_in_b_q;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: a small behavioural ALU answers the scheduler, and each
// scenario compares completions against results computed from the op codes.
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [4:0]  op0, op1;
    logic [31:0] a0, a1, b0, b1;
    logic        done0, done1;
    logic [31:0] result;
    logic        res_fault;
    logic        grant_id;
    logic        alu_available;
    logic [4:0]  alu_op;
    logic [31:0] alu_in_a, alu_in_b;
    logic [31:0] alu_out;
    logic        alu_busy, alu_fault;

    logic        alu_started;
    logic        alu_hang;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        avail_g;
        logic        gid_g;
        logic [4:0]  op_g;
        logic [31:0] a_g;
        logic [31:0] b_g;
        logic        got;
        logic        which;
        int          cyc;
        logic [31:0] res;
        logic        flt;
        logic        avail_d;
        logic        done_after;
    } obs_t;

    alu_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .done0(done0), .done1(done1), .result(result), .res_fault(res_fault),
        .grant_id(grant_id), .alu_available(alu_available), .alu_op(alu_op),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .alu_out(alu_out), .alu_busy(alu_busy), .alu_fault(alu_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_BEQ:  return {31'd0, a == b};
            OP_BNE:  return {31'd0, a != b};
            default: return 32'd0;
        endcase
    endfunction

    // ALU: busy for one cycle after it sees alu_available, re-armed when it drops.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_started <= 1'b0;
            alu_busy    <= 1'b0;
            alu_out     <= 32'd0;
            alu_fault   <= 1'b0;
        end else if (!alu_available) begin
            alu_started <= 1'b0;
            alu_busy    <= 1'b0;
        end else if (!alu_started) begin
            if (!alu_hang) begin
                alu_started <= 1'b1;
                alu_busy    <= 1'b1;
                alu_out     <= 32'hDEAD_BEEF;
            end
        end else if (alu_busy) begin
            alu_busy  <= 1'b0;
            alu_out   <= alu_ref(alu_op, alu_in_a, alu_in_b);
            alu_fault <= !op_is_valid(alu_op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int budget, output obs_t o);
        if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        tick();
        o.avail_g = alu_available; o.gid_g = grant_id; o.op_g = alu_op; o.a_g = alu_in_a; o.b_g = alu_in_b;
        o.cyc = 1;
        while (!(done0 || done1) && o.cyc < budget) begin
            tick();
            o.cyc++;
        end
        o.got = done0 | done1; o.which = done1; o.res = result; o.flt = res_fault; o.avail_d = alu_available;
        if (id) req1 = 1'b0; else req0 = 1'b0;
        tick();
        o.done_after = done0 | done1;
        $display("txn req=%0d op=%0d a=%h b=%h -> done_id=%0d result=%h fault=%0d cycles=%0d",
                 id, op, a, b, o.which, o.res, o.flt, o.cyc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; alu_hang = 0;
        tick(); tick();
        n_checks++; if (alu_available !== 1'b0) begin n_fail++; $display("FAIL reset_avail got=%b exp=0", alu_available); end
        n_checks++; if ({done0, done1} !== 2'b00) begin n_fail++; $display("FAIL reset_done got=%b exp=00", {done0, done1}); end
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result); end
        n_checks++; if (res_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b exp=0", res_fault); end
        n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL reset_grant_id got=%b exp=1", grant_id); end
        n_checks++; if ({alu_op, alu_in_a, alu_in_b} !== 69'd0) begin n_fail++; $display("FAIL reset_alu_regs got=%h exp=0", {alu_op, alu_in_a, alu_in_b}); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (alu_available !== 1'b0) begin n_fail++; $display("FAIL reset_idle_avail got=%b exp=0", alu_available); end
        $display("reset: outputs checked");
    endtask

    task automatic test_single_add();
        obs_t o;
        run_txn(1'b0, OP_ADD, 32'd5, 32'd7, 20, o);
        n_checks++; if (o.avail_g !== 1'b1) begin n_fail++; $display("FAIL add_avail_at_grant got=%b exp=1", o.avail_g); end
        n_checks++; if (o.gid_g !== 1'b0) begin n_fail++; $display("FAIL add_grant_id got=%b exp=0", o.gid_g); end
        n_checks++; if (o.got !== 1'b1 || o.cyc != 4) begin n_fail++; $display("FAIL add_latency got=%0d/%b exp=4/1", o.cyc, o.got); end
        n_checks++; if (o.which !== 1'b0) begin n_fail++; $display("FAIL add_done_id got=%b exp=0", o.which); end
        n_checks++; if (o.res !== 32'd12) begin n_fail++; $display("FAIL add_result got=%h exp=%h", o.res, 32'd12); end
        n_checks++; if (o.flt !== 1'b0) begin n_fail++; $display("FAIL add_fault got=%b exp=0", o.flt); end
        n_checks++; if (o.avail_d !== 1'b0) begin n_fail++; $display("FAIL add_avail_in_done got=%b exp=0", o.avail_d); end
        n_checks++; if (o.done_after !== 1'b0) begin n_fail++; $display("FAIL add_done_width got=%b exp=0", o.done_after); end
    endtask

    task automatic test_random_ops(input int n);
        obs_t        o;
        logic        id;
        logic [4:0]  op;
        logic [31:0] a, b, exp_res;
        for (int i = 0; i < n; i++) begin
            id = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(9, 31)) : 5'($urandom_range(0, 8));
            a = $urandom; b = $urandom;
            exp_res = alu_ref(op, a, b);
            run_txn(id, op, a, b, 20, o);
            n_checks++; if ({o.gid_g, o.op_g, o.a_g, o.b_g} !== {id, op, a, b}) begin n_fail++; $display("FAIL rand_issue got=%h exp=%h", {o.gid_g, o.op_g, o.a_g, o.b_g}, {id, op, a, b}); end
            n_checks++; if (o.got !== 1'b1 || o.cyc != 4 || o.which !== id) begin n_fail++; $display("FAIL rand_done got=%b/%0d/%b exp=1/4/%b", o.got, o.cyc, o.which, id); end
            n_checks++; if (o.res !== exp_res) begin n_fail++; $display("FAIL rand_result got=%h exp=%h", o.res, exp_res); end
            n_checks++; if (o.flt !== (op > OP_BNE)) begin n_fail++; $display("FAIL rand_fault got=%b exp=%b", o.flt, op > OP_BNE); end
        end
    endtask

    task automatic test_round_robin(input bit rand_ops, input int n);
        logic [4:0]  op_r [2];
        logic [31:0] a_r [2];
        logic [31:0] b_r [2];
        logic        exp_next, prev_done, d0, d1, w;
        logic [31:0] exp_res;
        int          served, cyc, rearm;
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        op_r[0] = OP_XOR; a_r[0] = 32'hF0; b_r[0] = 32'h0F;
        op_r[1] = OP_SUB; a_r[1] = 32'd10; b_r[1] = 32'd3;
        if (rand_ops) begin
            for (int k = 0; k < 2; k++) begin
                op_r[k] = 5'($urandom_range(0, 8)); a_r[k] = $urandom; b_r[k] = $urandom;
            end
        end
        op0 = op_r[0]; a0 = a_r[0]; b0 = b_r[0];
        op1 = op_r[1]; a1 = a_r[1]; b1 = b_r[1];
        req0 = 1'b1; req1 = 1'b1;
        exp_next = 1'b0; prev_done = 1'b0; served = 0; cyc = 0; rearm = -1;
        while (served < n && cyc < 200) begin
            tick();
            cyc++;
            if (rearm == 0) begin op0 = op_r[0]; a0 = a_r[0]; b0 = b_r[0]; req0 = 1'b1; end
            if (rearm == 1) begin op1 = op_r[1]; a1 = a_r[1]; b1 = b_r[1]; req1 = 1'b1; end
            rearm = -1;
            d0 = done0; d1 = done1;
            if (d0 || d1) begin
                w = d1;
                exp_res = alu_ref(op_r[w], a_r[w], b_r[w]);
                n_checks++; if ((d0 && d1) || prev_done) begin n_fail++; $display("FAIL rr_done_shape got=%b%b prev=%b exp=one-hot single", d0, d1, prev_done); end
                n_checks++; if (w !== exp_next || grant_id !== exp_next) begin n_fail++; $display("FAIL rr_order got=%b gid=%b exp=%b", w, grant_id, exp_next); end
                n_checks++; if (result !== exp_res || res_fault !== 1'b0) begin n_fail++; $display("FAIL rr_result got=%h/%b exp=%h/0", result, res_fault, exp_res); end
                n_checks++; if (alu_available !== 1'b0) begin n_fail++; $display("FAIL rr_avail_gap got=%b exp=0", alu_available); end
                $display("rr completion %0d: done_id=%0d result=%h", served, w, result);
                served++;
                exp_next = ~exp_next;
                if (rand_ops) begin
                    if (w) req1 = 1'b0; else req0 = 1'b0;
                    op_r[w] = 5'($urandom_range(0, 8)); a_r[w] = $urandom; b_r[w] = $urandom;
                    rearm = int'(w);
                end
            end
            prev_done = d0 | d1;
        end
        n_checks++; if (served != n) begin n_fail++; $display("FAIL rr_count got=%0d exp=%0d", served, n); end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_pending();
        logic [31:0] a, b, c, d;
        int k;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        req0 = 1'b1; op0 = OP_ADD; a0 = a; b0 = b;
        tick(); tick();
        req1 = 1'b1; op1 = OP_AND; a1 = c; b1 = d;
        k = 0;
        while (!(done0 || done1) && k < 30) begin tick(); k++; end
        n_checks++; if ({done0, done1} !== 2'b10 || result !== a + b) begin n_fail++; $display("FAIL pend_first got=%b%b/%h exp=10/%h", done0, done1, result, a + b); end
        req0 = 1'b0;
        tick();
        k = 0;
        while (!(done0 || done1) && k < 30) begin tick(); k++; end
        n_checks++; if ({done0, done1} !== 2'b01 || result !== (c & d)) begin n_fail++; $display("FAIL pend_second got=%b%b/%h exp=01/%h", done0, done1, result, c & d); end
        req1 = 1'b0;
        tick();
        $display("pending: second requester served after first");
    endtask

    task automatic test_invalid();
        obs_t o;
        run_txn(1'b1, 5'b01001, $urandom, $urandom, 20, o);
        n_checks++; if (o.got !== 1'b1 || o.which !== 1'b1 || o.cyc != 4) begin n_fail++; $display("FAIL inv_done got=%b/%b/%0d exp=1/1/4", o.got, o.which, o.cyc); end
        n_checks++; if (o.flt !== 1'b1) begin n_fail++; $display("FAIL inv_fault got=%b exp=1", o.flt); end
    endtask

    task automatic test_timeout();
        obs_t o;
        alu_hang = 1'b1;
        run_txn(1'b0, OP_ADD, 32'd1, 32'd2, 40, o);
        alu_hang = 1'b0;
        n_checks++; if (o.got !== 1'b1 || o.which !== 1'b0) begin n_fail++; $display("FAIL to_done got=%b/%b exp=1/0", o.got, o.which); end
        n_checks++; if (o.cyc != TO + 1) begin n_fail++; $display("FAIL to_latency got=%0d exp=%0d", o.cyc, TO + 1); end
        n_checks++; if (o.res !== 32'd0 || o.flt !== 1'b1) begin n_fail++; $display("FAIL to_result got=%h/%b exp=0/1", o.res, o.flt); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int n_done;
        req0 = 1'b1; op0 = OP_ADD; a0 = 32'd100; b0 = 32'd200;
        tick(); tick(); tick();
        n_checks++; if (alu_available !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got=%b exp=1", alu_available); end
        reset_n = 1'b0;
        #1;
        n_checks++; if ({alu_available, done0, done1, res_fault} !== 4'b0000 || result !== 32'd0) begin n_fail++; $display("FAIL rmid_outputs got=%b/%h exp=0000/0", {alu_available, done0, done1, res_fault}, result); end
        n_checks++; if ({alu_op, alu_in_a, alu_in_b} !== 69'd0 || grant_id !== 1'b1) begin n_fail++; $display("FAIL rmid_regs got=%h/%b exp=0/1", {alu_op, alu_in_a, alu_in_b}, grant_id); end
        req0 = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done0 || done1) n_done++; end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rmid_no_done got=%0d exp=0", n_done); end
        run_txn(1'b1, OP_BEQ, 32'd3, 32'd3, 20, o);
        n_checks++; if (o.got !== 1'b1 || o.which !== 1'b1 || o.gid_g !== 1'b1) begin n_fail++; $display("FAIL rmid_after_done got=%b/%b/%b exp=1/1/1", o.got, o.which, o.gid_g); end
        n_checks++; if (o.res !== 32'd1) begin n_fail++; $display("FAIL rmid_beq got=%h exp=1", o.res); end
    endtask

    task automatic test_drop_req();
        logic [31:0] a, b, got_res;
        logic        prev_avail;
        int          n_done0, n_done1, rises;
        a = $urandom; b = $urandom;
        req0 = 1'b1; op0 = OP_SUB; a0 = a; b0 = b;
        tick();
        tick();
        req0 = 1'b0;
        n_done0 = 0; n_done1 = 0; rises = 0; got_res = 32'd0; prev_avail = alu_available;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0) begin n_done0++; got_res = result; end
            if (done1) n_done1++;
            if (alu_available && !prev_avail) rises++;
            prev_avail = alu_available;
        end
        n_checks++; if (n_done0 != 1 || n_done1 != 0) begin n_fail++; $display("FAIL drop_done_count got=%0d/%0d exp=1/0", n_done0, n_done1); end
        n_checks++; if (got_res !== a - b) begin n_fail++; $display("FAIL drop_result got=%h exp=%h", got_res, a - b); end
        n_checks++; if (rises != 0 || alu_available !== 1'b0) begin n_fail++; $display("FAIL drop_regrant got=%0d/%b exp=0/0", rises, alu_available); end
        $display("drop: done0 pulses=%0d result=%h", n_done0, got_res);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_random_ops(12);
        test_invalid();
        test_round_robin(1'b0, 4);
        test_round_robin(1'b1, 8);
        test_pending();
        test_timeout();
        test_reset_mid();
        test_drop_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
